mem_line_arbiter: RTL and testbench
===================================

# mem_line_arbiter

Parametrised N-port cacheline arbiter between the L1 caches (instruction, data, and future L2/prefetch ports) and the single cacheline adapter port. It generalises the fixed two-port instruction/data arbiter to N requestors, selectable round-robin or fixed-priority grant, configurable line and address widths, and fully registered downstream outputs. One line transaction (read or write) is outstanding at a time.

## Interface

- N_PORTS, 2, number of requestor ports (≥2)
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, address width
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)
- ID_W, max(1, $clog2(N_PORTS)), grant index width (derived localparam)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_read  in  N_PORTS  per-port line read request
- req_write  in  N_PORTS  per-port line write request
- req_address  in  N_PORTS*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_PORTS*LINE_W  per-port write line; port i at [i*LINE_W +: LINE_W]
- req_resp  out  N_PORTS  one-hot completion pulse
- req_rdata  out  LINE_W  read line, shared by all ports, valid with req_resp
- mem_address  out  ADDR_W  to cacheline adapter
- mem_read  out  1  to cacheline adapter
- mem_write  out  1  to cacheline adapter
- mem_line_write  out  LINE_W  to cacheline adapter
- mem_line_read  in  LINE_W  from cacheline adapter
- mem_resp  in  1  from cacheline adapter
- busy  out  1  transaction in progress (state ≠ IDLE)
- grant_id  out  ID_W  index of current/last granted port

## Operation

- States: IDLE, BUSY, DONE.
- IDLE: if any port has req_read|req_write, select winner, latch its address, wdata, op type and index; go BUSY. Otherwise stay.
- Round-robin: search from (last_grant+1) mod N_PORTS upward with wrap; last_grant updates on each grant. Reset value of last_grant = N_PORTS-1, so port 0 wins first.
- Fixed priority: lowest-index requesting port wins; last_grant unused.
- Port asserting both read and write: treated as write.
- BUSY: mem_read or mem_write (exactly one) held high with latched address/data. On mem_resp=1: latch mem_line_read into req_rdata (reads only; writes leave req_rdata unchanged), drop mem_read/mem_write at next edge, go DONE.
- DONE: req_resp[grant_id]=1 for exactly one cycle; go IDLE.
- Requests from non-granted ports are held by requestors and serviced later; no request is dropped.
- Requests arriving or withdrawn while BUSY/DONE are ignored until IDLE.
- mem_read and mem_write never both high; neither high outside BUSY.
- Reset (any time, including mid-BUSY): state IDLE, all outputs 0 (mem_*, req_resp, req_rdata, busy, grant_id), last_grant = N_PORTS-1. Adapter shares rst, so an aborted transaction is not resumed.

## Timing

- All outputs are registered.
- Request sampled in IDLE at edge E → mem_read/mem_write high from E (cycle E+1 visible).
- mem_resp sampled high at edge R → req_resp pulse and req_rdata valid during cycle after R; state IDLE one cycle later.
- Arbiter overhead: 2 cycles beyond adapter latency (1 grant, 1 response). Minimum request-to-resp: adapter latency + 2.
- Requestor must deassert its request in the cycle following req_resp; arbiter re-samples in IDLE (one idle cycle between back-to-back transactions).
- Sustained contention, round-robin: each of K requesting ports is granted once per K transactions; no port waits more than N_PORTS-1 transactions.

## Test plan

- Single read: port 1 reads 0x0000_1040, adapter returns line 0xA5.. after 4 cycles → mem_read high with address 0x0000_1040, req_resp = 2'b10 for one cycle with req_rdata = 0xA5.., mem_read low at that cycle.
- Round-robin contention: N_PORTS=4, all ports read continuously → grant order 0,1,2,3,0,1; each req_resp one-hot matches grant_id.
- Fixed priority: PRIORITY_MODE=1, ports 0 and 2 request together, port 0 re-requests after resp → port 0 granted twice before port 2.
- Write: port 0 writes 0x0000_2000 with line 0xDEAD..BEEF → mem_write high, mem_line_write = 0xDEAD..BEEF, mem_read never high, req_rdata unchanged.
- Read+write on same port: port 1 asserts both → mem_write transaction only.
- Reset mid-BUSY: assert rst two cycles into a read → all outputs 0 asynchronously, busy=0; after release, port 0 wins first in round-robin mode.

Source files
------------

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: N-port cacheline arbiter in front of a single cacheline
// adapter. One line transaction is outstanding at a time; the grant policy
// is round-robin or fixed priority, and every output comes from a register.
module mem_line_arbiter #(
  parameter int N_PORTS       = 2,
  parameter int LINE_W        = 256,
  parameter int ADDR_W        = 32,
  parameter int PRIORITY_MODE = 0,
  localparam int ID_W         = (N_PORTS > 2) ? $clog2(N_PORTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         req_read,
  input  logic [N_PORTS-1:0]         req_write,
  input  logic [N_PORTS*ADDR_W-1:0]  req_address,
  input  logic [N_PORTS*LINE_W-1:0]  req_wdata,
  output logic [N_PORTS-1:0]         req_resp,
  output logic [LINE_W-1:0]          req_rdata,
  output logic [ADDR_W-1:0]          mem_address,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [LINE_W-1:0]          mem_line_write,
  input  logic [LINE_W-1:0]          mem_line_read,
  input  logic                       mem_resp,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     last_grant, last_grant_next;
  logic [ID_W-1:0]     grant_id_next;
  logic [ADDR_W-1:0]   mem_address_next;
  logic [LINE_W-1:0]   mem_line_write_next;
  logic                mem_read_next, mem_write_next;
  logic [LINE_W-1:0]   req_rdata_next;
  logic [N_PORTS-1:0]  req_resp_next;
  logic                busy_next;

  // Per-port views of the flattened address and write-data buses.
  logic [ADDR_W-1:0]   addr_arr  [N_PORTS];
  logic [LINE_W-1:0]   wdata_arr [N_PORTS];
  logic [N_PORTS-1:0]  req_any;

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_address[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*LINE_W +: LINE_W];
    end
  endgenerate

  assign req_any = req_read | req_write;

  logic            found;
  logic [ID_W-1:0] winner;

  // Winner selection. Both loops run from the lowest-precedence candidate to
  // the highest so the last hit (highest precedence) is the one that sticks.
  always_comb begin
    logic [ID_W-1:0] cand;
    int              idx;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    idx    = 0;
    if (PRIORITY_MODE != 0) begin
      for (int i = N_PORTS - 1; i >= 0; i--) begin
        cand = ID_W'(i);
        if (req_any[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end else begin
      for (int off = N_PORTS; off >= 1; off--) begin
        idx  = (int'(last_grant) + off) % N_PORTS;
        cand = ID_W'(idx);
        if (req_any[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  // Next-state and next-output logic; outputs hold unless a state changes them.
  always_comb begin
    state_next          = state;
    last_grant_next     = last_grant;
    grant_id_next       = grant_id;
    mem_address_next    = mem_address;
    mem_line_write_next = mem_line_write;
    mem_read_next       = mem_read;
    mem_write_next      = mem_write;
    req_rdata_next      = req_rdata;
    req_resp_next       = '0;
    busy_next           = busy;
    case (state)
      IDLE: begin
        if (found) begin
          state_next          = BUSY;
          grant_id_next       = winner;
          if (PRIORITY_MODE == 0) last_grant_next = winner;
          mem_address_next    = addr_arr[winner];
          mem_line_write_next = wdata_arr[winner];
          // A port raising both read and write is serviced as a write.
          mem_write_next      = req_write[winner];
          mem_read_next       = ~req_write[winner];
          busy_next           = 1'b1;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          if (!mem_write) req_rdata_next = mem_line_read;
          mem_read_next           = 1'b0;
          mem_write_next          = 1'b0;
          req_resp_next[grant_id] = 1'b1;
          state_next              = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        state_next     = IDLE;
        mem_read_next  = 1'b0;
        mem_write_next = 1'b0;
        busy_next      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= ID_W'(N_PORTS - 1);
      grant_id       <= '0;
      mem_address    <= '0;
      mem_line_write <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      req_rdata      <= '0;
      req_resp       <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_next;
      last_grant     <= last_grant_next;
      grant_id       <= grant_id_next;
      mem_address    <= mem_address_next;
      mem_line_write <= mem_line_write_next;
      mem_read       <= mem_read_next;
      mem_write      <= mem_write_next;
      req_rdata      <= req_rdata_next;
      req_resp       <= req_resp_next;
      busy           <= busy_next;
    end
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Testbench for mem_line_arbiter: a 4-port round-robin instance with full
// width lines and a 4-port fixed-priority instance with narrow lines, each
// with a behavioural adapter and a scoreboard of expected completions.
module tb_mem_line_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Round-robin instance
  logic [3:0]    rr_req_read = '0, rr_req_write = '0;
  logic [127:0]  rr_req_address = '0;
  logic [1023:0] rr_req_wdata = '0;
  logic [3:0]    rr_req_resp;
  logic [255:0]  rr_req_rdata, rr_mem_line_write;
  logic [255:0]  rr_mem_line_read = '0;
  logic [31:0]   rr_mem_address;
  logic          rr_mem_read, rr_mem_write, rr_busy;
  logic          rr_mem_resp = 1'b0;
  logic [1:0]    rr_grant_id;

  mem_line_arbiter #(.N_PORTS(4), .LINE_W(256), .ADDR_W(32), .PRIORITY_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .req_read(rr_req_read), .req_write(rr_req_write),
    .req_address(rr_req_address), .req_wdata(rr_req_wdata),
    .req_resp(rr_req_resp), .req_rdata(rr_req_rdata),
    .mem_address(rr_mem_address), .mem_read(rr_mem_read), .mem_write(rr_mem_write),
    .mem_line_write(rr_mem_line_write), .mem_line_read(rr_mem_line_read),
    .mem_resp(rr_mem_resp), .busy(rr_busy), .grant_id(rr_grant_id)
  );

  // Fixed-priority instance
  logic [3:0]   fp_req_read = '0, fp_req_write = '0;
  logic [63:0]  fp_req_address = '0;
  logic [127:0] fp_req_wdata = '0;
  logic [3:0]   fp_req_resp;
  logic [31:0]  fp_req_rdata, fp_mem_line_write;
  logic [31:0]  fp_mem_line_read = '0;
  logic [15:0]  fp_mem_address;
  logic         fp_mem_read, fp_mem_write, fp_busy;
  logic         fp_mem_resp = 1'b0;
  logic [1:0]   fp_grant_id;

  mem_line_arbiter #(.N_PORTS(4), .LINE_W(32), .ADDR_W(16), .PRIORITY_MODE(1)) u_fp (
    .clk(clk), .rst(rst),
    .req_read(fp_req_read), .req_write(fp_req_write),
    .req_address(fp_req_address), .req_wdata(fp_req_wdata),
    .req_resp(fp_req_resp), .req_rdata(fp_req_rdata),
    .mem_address(fp_mem_address), .mem_read(fp_mem_read), .mem_write(fp_mem_write),
    .mem_line_write(fp_mem_line_write), .mem_line_read(fp_mem_line_read),
    .mem_resp(fp_mem_resp), .busy(fp_busy), .grant_id(fp_grant_id)
  );

  typedef struct {
    int           port;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
  } exp_t;

  exp_t rr_q[$];
  exp_t fp_q[$];
  int   rr_done = 0;
  int   fp_done = 0;
  logic [255:0] rr_last_rdata = '0;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rr_line(input logic [31:0] a);
    return {32{8'hA5}} ^ {8{a ^ 32'h0000_1040}};
  endfunction

  function automatic logic [31:0] fp_line(input logic [15:0] a);
    return {a, ~a};
  endfunction

  // Behavioural adapters: respond a fixed number of cycles after a request.
  int rr_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      rr_mem_resp = 1'b0;
      rr_cnt = 0;
    end else if (rr_mem_resp) begin
      rr_mem_resp = 1'b0;
    end else if (rr_mem_read || rr_mem_write) begin
      rr_cnt++;
      if (rr_cnt == 4) begin
        rr_cnt = 0;
        rr_mem_resp = 1'b1;
        rr_mem_line_read = rr_line(rr_mem_address);
      end
    end
  end

  int fp_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      fp_mem_resp = 1'b0;
      fp_cnt = 0;
    end else if (fp_mem_resp) begin
      fp_mem_resp = 1'b0;
    end else if (fp_mem_read || fp_mem_write) begin
      fp_cnt++;
      if (fp_cnt == 2) begin
        fp_cnt = 0;
        fp_mem_resp = 1'b1;
        fp_mem_line_read = fp_line(fp_mem_address);
      end
    end
  end

  // Round-robin monitor: checks each adapter request and each completion.
  logic rr_prev_op = 1'b0;
  logic rr_prev_resp = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] onehot;
    if (rst) begin
      rr_prev_op = 1'b0;
      rr_prev_resp = 1'b0;
    end else begin
      if ((rr_mem_read || rr_mem_write) && !rr_prev_op) begin
        if (rr_q.size() == 0) begin
          check("rr_unexpected_op", {rr_mem_read, rr_mem_write}, 2'b00);
        end else begin
          check("rr_mem_address", rr_mem_address, rr_q[0].addr);
          check("rr_mem_write", rr_mem_write, rr_q[0].wr);
          check("rr_mem_read", rr_mem_read, !rr_q[0].wr);
          if (rr_q[0].wr) check("rr_mem_line_write", rr_mem_line_write, rr_q[0].wdata);
        end
      end
      if (rr_prev_resp) check("rr_resp_pulse", rr_req_resp, 4'b0000);
      if (rr_req_resp != 4'b0000) begin
        if (rr_q.size() == 0) begin
          check("rr_unexpected_resp", rr_req_resp, 4'b0000);
        end else begin
          e = rr_q.pop_front();
          onehot = 4'b0001 << e.port;
          check("rr_req_resp", rr_req_resp, onehot);
          check("rr_grant_id", rr_grant_id, e.port);
          check("rr_req_rdata", rr_req_rdata, e.rdata);
          check("rr_mem_idle_at_resp", {rr_mem_read, rr_mem_write}, 2'b00);
          check("rr_busy_at_resp", rr_busy, 1'b1);
          $display("[TB] rr txn port %0d %s addr %h", e.port, e.wr ? "write" : "read", e.addr);
        end
        rr_done++;
      end
      rr_prev_op = rr_mem_read || rr_mem_write;
      rr_prev_resp = (rr_req_resp != 4'b0000);
    end
  end

  // Fixed-priority monitor: completion order and returned line.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] onehot;
    if (!rst && fp_req_resp != 4'b0000) begin
      if (fp_q.size() == 0) begin
        check("fp_unexpected_resp", fp_req_resp, 4'b0000);
      end else begin
        e = fp_q.pop_front();
        onehot = 4'b0001 << e.port;
        check("fp_req_resp", fp_req_resp, onehot);
        check("fp_req_rdata", fp_req_rdata, e.rdata);
        $display("[TB] fp txn port %0d read addr %h", e.port, e.addr);
      end
      fp_done++;
    end
  end

  task automatic rr_push(input int port, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wdata);
    exp_t e;
    e.port = port;
    e.wr = wr;
    e.addr = addr;
    e.wdata = wdata;
    if (!wr) rr_last_rdata = rr_line(addr);
    e.rdata = rr_last_rdata;
    rr_q.push_back(e);
  endtask

  task automatic fp_push(input int port, input logic [15:0] addr);
    exp_t e;
    e.port = port;
    e.wr = 1'b0;
    e.addr = {16'h0, addr};
    e.wdata = '0;
    e.rdata = {224'h0, fp_line(addr)};
    fp_q.push_back(e);
  endtask

  task automatic wait_rr(input int target, input int budget);
    int n = 0;
    while (rr_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rr_wait_done", rr_done, target);
  endtask

  task automatic wait_fp(input int target, input int budget);
    int n = 0;
    while (fp_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("fp_wait_done", fp_done, target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int target;
    logic [255:0] wline;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", rr_busy, 1'b0);
    check("rst_grant_id", rr_grant_id, 2'd0);
    check("rst_req_resp", rr_req_resp, 4'b0000);
    check("rst_req_rdata", rr_req_rdata, 256'h0);
    check("rst_mem_ops", {rr_mem_read, rr_mem_write}, 2'b00);
    check("rst_mem_address", rr_mem_address, 32'h0);
    check("rst_mem_line_write", rr_mem_line_write, 256'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single read on port 1
    rr_push(1, 1'b0, 32'h0000_1040, '0);
    rr_req_address[32 +: 32] = 32'h0000_1040;
    rr_req_read[1] = 1'b1;
    wait_rr(1, 50);
    rr_req_read = '0;
    @(negedge clk);

    // Write on port 0; read data register must keep the previous line
    wline = {8{32'hDEAD_BEEF}};
    rr_push(0, 1'b1, 32'h0000_2000, wline);
    rr_req_address[0 +: 32] = 32'h0000_2000;
    rr_req_wdata[0 +: 256] = wline;
    rr_req_write[0] = 1'b1;
    wait_rr(2, 50);
    rr_req_write = '0;
    @(negedge clk);

    // Read and write together on port 1 is a write
    wline = ~{8{32'hDEAD_BEEF}};
    rr_push(1, 1'b1, 32'h0000_2440, wline);
    rr_req_address[32 +: 32] = 32'h0000_2440;
    rr_req_wdata[256 +: 256] = wline;
    rr_req_read[1] = 1'b1;
    rr_req_write[1] = 1'b1;
    wait_rr(3, 50);
    rr_req_read = '0;
    rr_req_write = '0;
    @(negedge clk);

    // Reset two cycles into a read
    rr_push(2, 1'b0, 32'h0000_3000, '0);
    rr_req_address[64 +: 32] = 32'h0000_3000;
    rr_req_read[2] = 1'b1;
    n = 0;
    while (!rr_mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_mem_read_seen", rr_mem_read, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_mem_ops", {rr_mem_read, rr_mem_write}, 2'b00);
    check("abort_busy", rr_busy, 1'b0);
    check("abort_grant_id", rr_grant_id, 2'd0);
    check("abort_req_rdata", rr_req_rdata, 256'h0);
    check("abort_mem_address", rr_mem_address, 32'h0);
    rr_req_read = '0;
    rr_q.delete();
    rr_last_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin contention, all four ports reading continuously
    for (int i = 0; i < 4; i++) rr_req_address[i*32 +: 32] = 32'h0000_4000 + 32'(i * 64);
    for (int k = 0; k < 6; k++) rr_push(k % 4, 1'b0, 32'h0000_4000 + 32'((k % 4) * 64), '0);
    target = rr_done + 6;
    rr_req_read = 4'b1111;
    wait_rr(target, 200);
    rr_req_read = '0;
    repeat (2) @(negedge clk);

    // Fixed priority: port 0 keeps requesting for two grants before port 2
    fp_req_address[0 +: 16] = 16'h0100;
    fp_req_address[32 +: 16] = 16'h0200;
    fp_push(0, 16'h0100);
    fp_push(0, 16'h0100);
    fp_push(2, 16'h0200);
    fp_req_read = 4'b0101;
    wait_fp(2, 100);
    fp_req_read[0] = 1'b0;
    wait_fp(3, 100);
    fp_req_read = '0;
    repeat (3) @(negedge clk);

    check("rr_q_drained", rr_q.size(), 0);
    check("fp_q_drained", fp_q.size(), 0);
    check("end_idle", {rr_busy, fp_busy}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
